exec_alu_stage: RTL and testbench

- Execute-stage datapath of the single-cycle RV32I core.
- Contains operand-B select, a 32-bit ALU, the writeback-data select and the next-PC select with default.
- All results are registered once, so downstream logic sees them one cycle after the inputs.
- Sits between controller/register file (inputs) and counter/register-file write port (outputs).

---
 rtl/exec_alu_pkg.sv | 36 +++
 rtl/exec_key_mux.sv | 25 ++
 rtl/exec_alu_stage.sv | 168 ++++++++++++++++
 tb/tb_exec_alu_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_alu_pkg.sv
// Shared encodings for the RV32I execute stage: ALU opcodes, writeback and next-PC selects.
package exec_alu_pkg;

    localparam int ALU_OP_LEN = 4;
    localparam int WB_SEL_LEN = 2;
    localparam int PC_SEL_LEN = 2;

    typedef logic [ALU_OP_LEN-1:0] alu_op_t;
    typedef logic [WB_SEL_LEN-1:0] wb_sel_t;
    typedef logic [PC_SEL_LEN-1:0] pc_sel_t;

    localparam alu_op_t ALU_ADD   = 4'b0000;
    localparam alu_op_t ALU_SUB   = 4'b0001;
    localparam alu_op_t ALU_AND   = 4'b0010;
    localparam alu_op_t ALU_OR    = 4'b0011;
    localparam alu_op_t ALU_XOR   = 4'b0100;
    localparam alu_op_t ALU_SLL   = 4'b0101;
    localparam alu_op_t ALU_SRL   = 4'b0110;
    localparam alu_op_t ALU_SRA   = 4'b0111;
    localparam alu_op_t ALU_SLT   = 4'b1000;
    localparam alu_op_t ALU_SLTU  = 4'b1001;
    localparam alu_op_t ALU_PASSB = 4'b1010;

    localparam wb_sel_t WB_ALU    = 2'b00;
    localparam wb_sel_t WB_MEM    = 2'b01;
    localparam wb_sel_t WB_PCPLUS = 2'b10;
    localparam wb_sel_t WB_PCBR   = 2'b11;

    // Code 2'b11 is deliberately unnamed: it falls through to RESET_PC.
    localparam pc_sel_t PC_PLUS   = 2'b00;
    localparam pc_sel_t PC_BRANCH = 2'b01;
    localparam pc_sel_t PC_JALR   = 2'b10;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/exec_key_mux.sv
// Generic key/value selector: returns the value paired with the matching key, else default_value.
module exec_key_mux #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 32
) (
    input  logic [KEY_LEN-1:0]                    key,
    input  logic [DATA_LEN-1:0]                   default_value,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
    output logic [DATA_LEN-1:0]                   data_out
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    // Each lut entry is packed as {key, value}; entry 0 sits in the low bits.
    always_comb begin
        data_out = default_value;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
                data_out = lut[i*PAIR_LEN +: DATA_LEN];
            end
        end
    end

endmodule

// File: rtl/exec_alu_stage.sv
// Registered execute stage: operand-B select, 32-bit ALU, writeback select and next-PC select.
// Define EXEC_ALU_FLAGS_EN to add registered carry/overflow/negative outputs.
module exec_alu_stage
    import exec_alu_pkg::*;
#(
    parameter int                  DATA_LEN = 32,
    parameter int                  ADDR_LEN = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = exec_alu_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_LEN-1:0]   reg_data1,
    input  logic [DATA_LEN-1:0]   reg_data2,
    input  logic [DATA_LEN-1:0]   imm,
    input  logic                  alu_src,
    input  logic [3:0]            alu_control,
    input  logic [1:0]            mem_to_reg,
    input  logic [DATA_LEN-1:0]   read_data,
    input  logic [ADDR_LEN-1:0]   pc_plus,
    input  logic [ADDR_LEN-1:0]   pc_branch,
    input  logic [1:0]            pc_src,
    output logic                  out_valid,
    output logic [DATA_LEN-1:0]   alu_result,
    output logic                  zero,
    output logic [DATA_LEN-1:0]   wb_data,
    output logic [ADDR_LEN-1:0]   pc_next
`ifdef EXEC_ALU_FLAGS_EN
    ,
    output logic                  carry,
    output logic                  overflow,
    output logic                  negative
`endif
);

    localparam int SHAMT_LEN = $clog2(DATA_LEN);
    localparam int MSB       = DATA_LEN - 1;

    logic [DATA_LEN-1:0]  src_b;
    logic [DATA_LEN-1:0]  alu_comb;
    logic                 zero_comb;
    logic [DATA_LEN-1:0]  wb_comb;
    logic [ADDR_LEN-1:0]  pc_comb;
    logic [ADDR_LEN-1:0]  jalr_target;
    logic [SHAMT_LEN-1:0] shamt;

    exec_key_mux #(
        .NR_KEY   (2),
        .KEY_LEN  (1),
        .DATA_LEN (DATA_LEN)
    ) u_src_b_mux (
        .key           (alu_src),
        .default_value ('0),
        .lut           ({1'b1, imm, 1'b0, reg_data2}),
        .data_out      (src_b)
    );

    assign shamt = src_b[SHAMT_LEN-1:0];

    always_comb begin
        alu_comb = '0;
        case (alu_control)
            ALU_ADD:   alu_comb = reg_data1 + src_b;
            ALU_SUB:   alu_comb = reg_data1 - src_b;
            ALU_AND:   alu_comb = reg_data1 & src_b;
            ALU_OR:    alu_comb = reg_data1 | src_b;
            ALU_XOR:   alu_comb = reg_data1 ^ src_b;
            ALU_SLL:   alu_comb = reg_data1 << shamt;
            ALU_SRL:   alu_comb = reg_data1 >> shamt;
            ALU_SRA:   alu_comb = $signed(reg_data1) >>> shamt;
            ALU_SLT:   alu_comb = {{(DATA_LEN-1){1'b0}}, $signed(reg_data1) < $signed(src_b)};
            ALU_SLTU:  alu_comb = {{(DATA_LEN-1){1'b0}}, reg_data1 < src_b};
            ALU_PASSB: alu_comb = src_b;
            default:   alu_comb = '0;
        endcase
    end

    assign zero_comb = (alu_comb == '0);

    // Writeback select is fully decoded, so the default value never propagates.
    exec_key_mux #(
        .NR_KEY   (4),
        .KEY_LEN  (2),
        .DATA_LEN (DATA_LEN)
    ) u_wb_mux (
        .key           (mem_to_reg),
        .default_value ('0),
        .lut           ({WB_PCBR,   DATA_LEN'(pc_branch),
                         WB_PCPLUS, DATA_LEN'(pc_plus),
                         WB_MEM,    read_data,
                         WB_ALU,    alu_comb}),
        .data_out      (wb_comb)
    );

    assign jalr_target = ADDR_LEN'(alu_comb) & ~ADDR_LEN'(1);

    exec_key_mux #(
        .NR_KEY   (3),
        .KEY_LEN  (2),
        .DATA_LEN (ADDR_LEN)
    ) u_pc_mux (
        .key           (pc_src),
        .default_value (RESET_PC),
        .lut           ({PC_JALR,   jalr_target,
                         PC_BRANCH, pc_branch,
                         PC_PLUS,   pc_plus}),
        .data_out      (pc_comb)
    );

`ifdef EXEC_ALU_FLAGS_EN
    logic [DATA_LEN:0] add_ext;
    logic [DATA_LEN:0] sub_ext;
    logic              carry_comb;
    logic              overflow_comb;

    // SUB carry is computed as A + ~B + 1, so its carry-out is the inverted borrow.
    always_comb begin
        add_ext       = {1'b0, reg_data1} + {1'b0, src_b};
        sub_ext       = {1'b0, reg_data1} + {1'b0, ~src_b} + {{DATA_LEN{1'b0}}, 1'b1};
        carry_comb    = 1'b0;
        overflow_comb = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                carry_comb    = add_ext[DATA_LEN];
                overflow_comb = (reg_data1[MSB] == src_b[MSB]) && (add_ext[MSB] != reg_data1[MSB]);
            end
            ALU_SUB: begin
                carry_comb    = sub_ext[DATA_LEN];
                overflow_comb = (reg_data1[MSB] != src_b[MSB]) && (sub_ext[MSB] != reg_data1[MSB]);
            end
            default: begin
                carry_comb    = 1'b0;
                overflow_comb = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
        end else begin
            carry    <= carry_comb;
            overflow <= overflow_comb;
            negative <= alu_comb[MSB];
        end
    end
`endif

    // Datapath registers load every cycle; in_valid only qualifies the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            alu_result <= '0;
            zero       <= 1'b0;
            wb_data    <= '0;
            pc_next    <= RESET_PC;
        end else begin
            out_valid  <= in_valid;
            alu_result <= alu_comb;
            zero       <= zero_comb;
            wb_data    <= wb_comb;
            pc_next    <= pc_comb;
        end
    end

endmodule

// File: tb/tb_exec_alu_stage.sv
// Scoreboard bench for exec_alu_stage: directed vectors push expectations, a monitor pops and checks.
module tb_exec_alu_stage;
    import exec_alu_pkg::*;

    localparam logic [31:0] PP  = 32'h8000_0004;
    localparam logic [31:0] PB  = 32'h8000_0100;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] reg_data1, reg_data2, imm, read_data, pc_plus, pc_branch;
    logic        alu_src;
    logic [3:0]  alu_control;
    logic [1:0]  mem_to_reg, pc_src;
    logic        out_valid, zero;
    logic [31:0] alu_result, wb_data, pc_next;
`ifdef EXEC_ALU_FLAGS_EN
    logic        carry, overflow, negative;
`endif

    always #5 clk = ~clk;

    exec_alu_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .reg_data1   (reg_data1),
        .reg_data2   (reg_data2),
        .imm         (imm),
        .alu_src     (alu_src),
        .alu_control (alu_control),
        .mem_to_reg  (mem_to_reg),
        .read_data   (read_data),
        .pc_plus     (pc_plus),
        .pc_branch   (pc_branch),
        .pc_src      (pc_src),
        .out_valid   (out_valid),
        .alu_result  (alu_result),
        .zero        (zero),
        .wb_data     (wb_data),
        .pc_next     (pc_next)
`ifdef EXEC_ALU_FLAGS_EN
        ,
        .carry       (carry),
        .overflow    (overflow),
        .negative    (negative)
`endif
    );

    typedef struct packed {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] wb;
        logic [31:0] pc;
        logic        carry;
        logic        overflow;
        logic        negative;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b2;
        logic [31:0] imm;
        logic        src;
        logic [3:0]  op;
        logic [1:0]  m2r;
        logic [1:0]  pcs;
        logic        valid;
        exp_t        exp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b2, input logic [31:0] im,
                                input logic src, input logic [3:0] op, input logic [1:0] m2r,
                                input logic [1:0] pcs, input logic [31:0] e_alu, input logic e_zero,
                                input logic [31:0] e_wb, input logic [31:0] e_pc,
                                input logic e_carry, input logic e_ov);
        vec_t v;
        v.a     = a;
        v.b2    = b2;
        v.imm   = im;
        v.src   = src;
        v.op    = op;
        v.m2r   = m2r;
        v.pcs   = pcs;
        v.valid = 1'b1;
        v.exp.alu      = e_alu;
        v.exp.zero     = e_zero;
        v.exp.wb       = e_wb;
        v.exp.pc       = e_pc;
        v.exp.carry    = e_carry;
        v.exp.overflow = e_ov;
        v.exp.negative = e_alu[31];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid    = v.valid;
        reg_data1   = v.a;
        reg_data2   = v.b2;
        imm         = v.imm;
        alu_src     = v.src;
        alu_control = v.op;
        mem_to_reg  = v.m2r;
        pc_src      = v.pcs;
        if (v.valid) exp_q.push_back(v.exp);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " out_valid"},  {31'b0, out_valid}, 32'h0);
        checkOutput({tag, " alu_result"}, alu_result, 32'h0);
        checkOutput({tag, " zero"},       {31'b0, zero}, 32'h0);
        checkOutput({tag, " wb_data"},    wb_data, 32'h0);
        checkOutput({tag, " pc_next"},    pc_next, RPC);
`ifdef EXEC_ALU_FLAGS_EN
        checkOutput({tag, " flags"},      {29'b0, carry, overflow, negative}, 32'h0);
`endif
    endtask

    // Monitor: every valid output beat must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_valid: got out_valid=1, required no output");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("alu_result", alu_result, e.alu);
                    checkOutput("zero", {31'b0, zero}, {31'b0, e.zero});
                    checkOutput("wb_data", wb_data, e.wb);
                    checkOutput("pc_next", pc_next, e.pc);
`ifdef EXEC_ALU_FLAGS_EN
                    checkOutput("carry", {31'b0, carry}, {31'b0, e.carry});
                    checkOutput("overflow", {31'b0, overflow}, {31'b0, e.overflow});
                    checkOutput("negative", {31'b0, negative}, {31'b0, e.negative});
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        read_data = 32'h0000_00AA;
        pc_plus   = PP;
        pc_branch = PB;

        vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_1234, 32'h1, 1'b1, ALU_ADD, WB_ALU, PC_PLUS,
                          32'h0, 1'b1, 32'h0, PP, 1'b1, 1'b0));
        vecs.push_back(mk(32'h5, 32'h7, 32'h0, 1'b0, ALU_SUB, WB_ALU, PC_PLUS,
                          32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFF_FFFE, 32'h1, 32'h0, 1'b0, ALU_SLT, WB_ALU, PC_PLUS,
                          32'h1, 1'b0, 32'h1, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFF_FFFE, 32'h1, 32'h0, 1'b0, ALU_SLTU, WB_ALU, PC_PLUS,
                          32'h0, 1'b1, 32'h0, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'h0, 32'h21, 1'b1, ALU_SRA, WB_ALU, PC_PLUS,
                          32'hC000_0000, 1'b0, 32'hC000_0000, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'h0, 32'h21, 1'b1, ALU_SRL, WB_ALU, PC_PLUS,
                          32'h4000_0000, 1'b0, 32'h4000_0000, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'h1, 32'h1F, 32'h0, 1'b0, ALU_SLL, WB_ALU, PC_PLUS,
                          32'h8000_0000, 1'b0, 32'h8000_0000, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 1'b0, ALU_AND, WB_ALU, PC_PLUS,
                          32'hF000_F000, 1'b0, 32'hF000_F000, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 1'b0, ALU_OR, WB_ALU, PC_PLUS,
                          32'hFFF0_FFF0, 1'b0, 32'hFFF0_FFF0, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 1'b0, ALU_XOR, WB_ALU, PC_PLUS,
                          32'h0FF0_0FF0, 1'b0, 32'h0FF0_0FF0, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'h0, 32'h0000_FFFF, 32'h1234_5000, 1'b1, ALU_PASSB, WB_ALU, PC_PLUS,
                          32'h1234_5000, 1'b0, 32'h1234_5000, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'h5, 32'h5, 32'h0, 1'b0, 4'b1011, WB_ALU, PC_PLUS,
                          32'h0, 1'b1, 32'h0, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'h7, 32'h7, 32'h0, 1'b0, ALU_SUB, WB_ALU, PC_PLUS,
                          32'h0, 1'b1, 32'h0, PP, 1'b1, 1'b0));
        v = mk(32'h9, 32'h9, 32'h0, 1'b0, ALU_ADD, WB_ALU, PC_PLUS,
               32'h12, 1'b0, 32'h12, PP, 1'b0, 1'b0);
        v.valid = 1'b0;
        vecs.push_back(v);
        vecs.push_back(mk(32'h3, 32'h4, 32'h0, 1'b0, ALU_ADD, WB_ALU, PC_PLUS,
                          32'h7, 1'b0, 32'h7, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'h3, 32'h4, 32'h0, 1'b0, ALU_ADD, WB_MEM, PC_PLUS,
                          32'h7, 1'b0, 32'hAA, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'h3, 32'h4, 32'h0, 1'b0, ALU_ADD, WB_PCPLUS, PC_PLUS,
                          32'h7, 1'b0, PP, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'h3, 32'h4, 32'h0, 1'b0, ALU_ADD, WB_PCBR, PC_PLUS,
                          32'h7, 1'b0, PB, PP, 1'b0, 1'b0));
        vecs.push_back(mk(32'h8000_0011, 32'h0, 32'h0, 1'b0, ALU_ADD, WB_ALU, PC_JALR,
                          32'h8000_0011, 1'b0, 32'h8000_0011, 32'h8000_0010, 1'b0, 1'b0));
        vecs.push_back(mk(32'h8000_0011, 32'h0, 32'h0, 1'b0, ALU_ADD, WB_ALU, 2'b11,
                          32'h8000_0011, 1'b0, 32'h8000_0011, RPC, 1'b0, 1'b0));
        vecs.push_back(mk(32'h8000_0011, 32'h0, 32'h0, 1'b0, ALU_ADD, WB_ALU, PC_BRANCH,
                          32'h8000_0011, 1'b0, 32'h8000_0011, PB, 1'b0, 1'b0));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, ALU_ADD, WB_ALU, PC_PLUS,
                          32'h8000_0000, 1'b0, 32'h8000_0000, PP, 1'b0, 1'b1));

        // Reset held with random inputs toggling every cycle.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid    = 1'b1;
            reg_data1   = $urandom();
            reg_data2   = $urandom();
            imm         = $urandom();
            alu_src     = 1'($urandom_range(0, 1));
            alu_control = 4'($urandom_range(0, 15));
            mem_to_reg  = 2'($urandom_range(0, 3));
            pc_src      = 2'($urandom_range(0, 3));
            @(negedge clk);
            checkResetState("reset_hold");
        end

        // Release reset together with the first vector; its result appears one edge later.
        @(posedge clk);
        #1;
        applyStimulus(vecs[0]);
        rst = 1'b1;
        for (int i = 1; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d outstanding results, required 0", exp_q.size());
        end

        // Reset asynchronously while a captured result is still on the outputs.
        @(posedge clk);
        #1;
        applyStimulus(mk(32'h1, 32'h2, 32'h0, 1'b0, ALU_ADD, WB_ALU, PC_BRANCH,
                         32'h3, 1'b0, 32'h3, PB, 1'b0, 1'b0));
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        checkOutput("inflight alu_result", alu_result, 32'h3);
        #1;
        rst = 1'b0;
        #1;
        checkResetState("async_reset");
        @(posedge clk);
        #1;
        checkResetState("reset_after_edge");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
